linear_pe_stream_scheduler: RTL and testbench
=============================================

Name: linear_pe_stream_scheduler

Overview:
Job-level sequencer for a chain of LinearProcessingElementWrapper tiles. It frames untagged op0 and op1 operand streams into dot-product packets of cfg_len beats, adding tlast on the last beat of each. It also injects one zero partial-sum seed per dot product and collects the finished partial sums from the chain. It watches the PE misalignment error and, when it fires, aborts the job, holds the PE in reset, and reports a sticky error.

Parameters:
DATA_WIDTH_OP0, 16, op0 (left-edge) data width
DATA_WIDTH_OP1, 16, op1 (top-edge) data width
DATA_WIDTH_PSUM, 32, partial-sum width (equals DATA_WIDTH_OP0 + DATA_WIDTH_OP1)
LEN_WIDTH, 16, width of cfg_len and of the beat counters
CNT_WIDTH, 16, width of cfg_count and of the dot-product counters
PE_RST_CYCLES, 4, number of cycles pe_rst is held high after an error (minimum 1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cfg_start  in  1  one-cycle job start request
cfg_len  in  LEN_WIDTH  beats per dot product
cfg_count  in  CNT_WIDTH  dot products per job
busy  out  1  high while state != IDLE
done  out  1  one-cycle pulse when a job completes
err  out  1  sticky abort flag; cleared by an accepted cfg_start
s_axis_op0_tdata/tvalid/tready  in/in/out  DATA_WIDTH_OP0/1/1  upstream op0 stream
m_axis_l_tdata/tvalid/tready/tlast  out/out/in/out  DATA_WIDTH_OP0/1/1/1  to PE s_axis_l
s_axis_op1_tdata/tvalid/tready  in/in/out  DATA_WIDTH_OP1/1/1  upstream op1 stream
m_axis_t_tdata/tvalid/tready/tlast  out/out/in/out  DATA_WIDTH_OP1/1/1/1  to PE s_axis_t
m_axis_u_tdata/tvalid/tready/tlast  out/out/in/out  DATA_WIDTH_PSUM/1/1/1  zero seeds to PE s_axis_u
s_axis_d_tdata/tvalid/tready/tlast  in/in/out/in  DATA_WIDTH_PSUM/1/1/1  results from PE m_axis_d
m_axis_res_tdata/tvalid/tready/tlast  out/out/in/out  DATA_WIDTH_PSUM/1/1/1  results to consumer
pe_err_unalligned_data  in  1  PE err_unalligned_data
pe_rst  out  1  reset to the PE chain

Behaviour:
- Clock clk; reset rst is synchronous and active-high.
- Reset: state=IDLE; all counters 0; busy=0, done=0, err=0, pe_rst=0. All tvalid and tready outputs are 0 and all tlast outputs are 0. Reset mid-job abandons the job silently: no done pulse, err stays 0.
- States: IDLE, RUN, FLUSH.
- IDLE, accepted cfg_start:
  - If cfg_len!=0 and cfg_count!=0: latch both, clear all counters, clear err, go to RUN next cycle.
  - If either is 0: err is still cleared, done pulses on the next cycle, state stays IDLE.
- cfg_start outside IDLE is ignored.
- RUN, op0 path (combinational passthrough, zero latency):
  - m_axis_l_tdata = s_axis_op0_tdata; m_axis_l_tvalid = s_axis_op0_tvalid & open0; s_axis_op0_tready = m_axis_l_tready & open0.
  - open0 = (dp0 < cfg_count).
  - beat0 increments on each handshake. m_axis_l_tlast = (beat0 == cfg_len-1). On that beat, beat0 wraps to 0 and dp0 increments.
- RUN, op1 path: identical, independent counters beat1/dp1 and open1. The two paths never stall each other.
- RUN, seed path: m_axis_u_tdata = 0, tlast = 1, tvalid = (seeds < cfg_count). seeds increments per handshake. Seed count is independent of operand progress.
- RUN, result path: passthrough s_axis_d -> m_axis_res, with s_axis_d_tready = m_axis_res_tready.
  - m_axis_res_tlast = (res == cfg_count-1). The incoming s_axis_d_tlast is ignored.
  - res increments per handshake. On the handshake where res == cfg_count-1, the next state is IDLE and done pulses on the following cycle.
- Seeds, results and either operand stream may complete in any order.
- Error: pe_err_unalligned_data sampled high in RUN -> FLUSH next cycle, and err is set.
- FLUSH:
  - All tvalid and tready outputs are 0 and all tlast outputs are 0.
  - pe_rst = 1 for exactly PE_RST_CYCLES cycles, then state=IDLE. No done pulse.
  - Upstream data is not consumed; the upstream owner must flush it.
- pe_err_unalligned_data is ignored in IDLE and FLUSH.
- If error and final result handshake occur in the same cycle, the error wins: the result is accepted, but the state goes to FLUSH and there is no done pulse.
- IDLE: all stream tvalid and tready outputs are 0.
- Counters saturate by construction (gated by open/limit); no wrap beyond cfg_count.
- AXI-Stream rules are preserved: once downstream tvalid is asserted, it is not deasserted and tdata does not change until the handshake. The passthrough inherits this from upstream.

Test Plan:
- Normal job: cfg_len=5, cfg_count=3; op0/op1 feed 15 beats each; PE returns 3 results.
  - Required: l/t tlast on beats 4, 9, 14; exactly 3 zero seeds, each with tlast=1.
  - Required: res_tlast only on the 3rd result; done is 1 cycle after it; busy drops at the same edge; err=0.
- Backpressure: m_axis_l_tready toggles 1-0-1 every cycle, m_axis_t_tready is held at 1, cfg_len=4, cfg_count=2.
  - Required: op1 completes 8 beats unaffected; op0 tdata is stable while stalled; tlast fires only on handshaked beats 3 and 7.
- Misalignment: pe_err_unalligned_data pulses after beat 7 of cfg_len=5, cfg_count=4.
  - Required: next cycle state=FLUSH; err=1; pe_rst high for exactly 4 cycles; all valids/readies 0; no done; return to IDLE.
  - Required: a new cfg_start clears err.
- Zero config: cfg_start with cfg_count=0 -> done pulse 1 cycle later; busy stays 0; no stream activity.
- Ignored start and mid-job reset:
  - cfg_start asserted during RUN -> no effect on the counters.
  - rst asserted mid-RUN -> all outputs at reset values next cycle; no done.
- Out-of-order completion: results are held off until all operands and seeds are sent, then released -> job still completes with done after the last result.

Source files
------------

// File: rtl/linear_pe_stream_scheduler.sv
// Job sequencer for a LinearProcessingElementWrapper chain: frames op0/op1 into
// cfg_len-beat packets, seeds one zero psum per dot product, collects results.
module linear_pe_stream_scheduler #(
  parameter int DATA_WIDTH_OP0  = 16,
  parameter int DATA_WIDTH_OP1  = 16,
  parameter int DATA_WIDTH_PSUM = 32,
  parameter int LEN_WIDTH       = 16,
  parameter int CNT_WIDTH       = 16,
  parameter int PE_RST_CYCLES   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_start,
  input  logic [LEN_WIDTH-1:0]       cfg_len,
  input  logic [CNT_WIDTH-1:0]       cfg_count,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  input  logic [DATA_WIDTH_OP0-1:0]  s_axis_op0_tdata,
  input  logic                       s_axis_op0_tvalid,
  output logic                       s_axis_op0_tready,
  output logic [DATA_WIDTH_OP0-1:0]  m_axis_l_tdata,
  output logic                       m_axis_l_tvalid,
  input  logic                       m_axis_l_tready,
  output logic                       m_axis_l_tlast,
  input  logic [DATA_WIDTH_OP1-1:0]  s_axis_op1_tdata,
  input  logic                       s_axis_op1_tvalid,
  output logic                       s_axis_op1_tready,
  output logic [DATA_WIDTH_OP1-1:0]  m_axis_t_tdata,
  output logic                       m_axis_t_tvalid,
  input  logic                       m_axis_t_tready,
  output logic                       m_axis_t_tlast,
  output logic [DATA_WIDTH_PSUM-1:0] m_axis_u_tdata,
  output logic                       m_axis_u_tvalid,
  input  logic                       m_axis_u_tready,
  output logic                       m_axis_u_tlast,
  input  logic [DATA_WIDTH_PSUM-1:0] s_axis_d_tdata,
  input  logic                       s_axis_d_tvalid,
  output logic                       s_axis_d_tready,
  input  logic                       s_axis_d_tlast,
  output logic [DATA_WIDTH_PSUM-1:0] m_axis_res_tdata,
  output logic                       m_axis_res_tvalid,
  input  logic                       m_axis_res_tready,
  output logic                       m_axis_res_tlast,
  input  logic                       pe_err_unalligned_data,
  output logic                       pe_rst
);

  // Handshake rule on every stream: a beat transfers on a clock edge where
  // tvalid && tready; tvalid never drops and tdata never changes before that.

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_e;

  localparam int RST_W = (PE_RST_CYCLES > 1) ? $clog2(PE_RST_CYCLES) : 1;
  localparam logic [RST_W-1:0]     RST_LAST = RST_W'(PE_RST_CYCLES - 1);
  localparam logic [RST_W-1:0]     RST_ONE  = RST_W'(1);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [LEN_WIDTH-1:0] beat0_q, beat0_d, beat1_q, beat1_d;
  logic [CNT_WIDTH-1:0] dp0_q, dp0_d, dp1_q, dp1_d;
  logic [CNT_WIDTH-1:0] seeds_q, seeds_d, res_q, res_d;
  logic [RST_W-1:0]     rst_cnt_q, rst_cnt_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic run, open0, open1, last0, last1, res_last;
  logic hs_l, hs_t, hs_u, hs_res;
  logic unused_d_tlast;

  assign unused_d_tlast = s_axis_d_tlast;

  assign run      = (state_q == S_RUN);
  assign open0    = (dp0_q < count_q);
  assign open1    = (dp1_q < count_q);
  assign last0    = (beat0_q == (len_q - LEN_ONE));
  assign last1    = (beat1_q == (len_q - LEN_ONE));
  assign res_last = (res_q == (count_q - CNT_ONE));

  assign m_axis_l_tdata    = s_axis_op0_tdata;
  assign m_axis_l_tvalid   = run & open0 & s_axis_op0_tvalid;
  assign s_axis_op0_tready = run & open0 & m_axis_l_tready;
  assign m_axis_l_tlast    = run & last0;

  assign m_axis_t_tdata    = s_axis_op1_tdata;
  assign m_axis_t_tvalid   = run & open1 & s_axis_op1_tvalid;
  assign s_axis_op1_tready = run & open1 & m_axis_t_tready;
  assign m_axis_t_tlast    = run & last1;

  assign m_axis_u_tdata    = '0;
  assign m_axis_u_tvalid   = run & (seeds_q < count_q);
  assign m_axis_u_tlast    = run;

  // Result tlast is regenerated from our own count; the PE's tlast is not trusted.
  assign m_axis_res_tdata  = s_axis_d_tdata;
  assign m_axis_res_tvalid = run & s_axis_d_tvalid;
  assign s_axis_d_tready   = run & m_axis_res_tready;
  assign m_axis_res_tlast  = run & res_last;

  assign hs_l   = m_axis_l_tvalid & m_axis_l_tready;
  assign hs_t   = m_axis_t_tvalid & m_axis_t_tready;
  assign hs_u   = m_axis_u_tvalid & m_axis_u_tready;
  assign hs_res = m_axis_res_tvalid & m_axis_res_tready;

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign err    = err_q;
  assign pe_rst = (state_q == S_FLUSH);

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    count_d   = count_q;
    beat0_d   = beat0_q;
    beat1_d   = beat1_q;
    dp0_d     = dp0_q;
    dp1_d     = dp1_q;
    seeds_d   = seeds_q;
    res_d     = res_q;
    rst_cnt_d = rst_cnt_q;
    done_d    = 1'b0;
    err_d     = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          err_d = 1'b0;
          if ((cfg_len != '0) && (cfg_count != '0)) begin
            len_d   = cfg_len;
            count_d = cfg_count;
            beat0_d = '0;
            beat1_d = '0;
            dp0_d   = '0;
            dp1_d   = '0;
            seeds_d = '0;
            res_d   = '0;
            state_d = S_RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      S_RUN: begin
        if (hs_l) begin
          if (last0) begin
            beat0_d = '0;
            dp0_d   = dp0_q + CNT_ONE;
          end else begin
            beat0_d = beat0_q + LEN_ONE;
          end
        end
        if (hs_t) begin
          if (last1) begin
            beat1_d = '0;
            dp1_d   = dp1_q + CNT_ONE;
          end else begin
            beat1_d = beat1_q + LEN_ONE;
          end
        end
        if (hs_u) seeds_d = seeds_q + CNT_ONE;
        if (hs_res) begin
          res_d = res_q + CNT_ONE;
          if (res_last) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
        // An error in the same cycle as the final result still aborts the job.
        if (pe_err_unalligned_data) begin
          state_d   = S_FLUSH;
          err_d     = 1'b1;
          done_d    = 1'b0;
          rst_cnt_d = '0;
        end
      end

      S_FLUSH: begin
        if (rst_cnt_q == RST_LAST) state_d = S_IDLE;
        else                       rst_cnt_d = rst_cnt_q + RST_ONE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      count_q   <= '0;
      beat0_q   <= '0;
      beat1_q   <= '0;
      dp0_q     <= '0;
      dp1_q     <= '0;
      seeds_q   <= '0;
      res_q     <= '0;
      rst_cnt_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      count_q   <= count_d;
      beat0_q   <= beat0_d;
      beat1_q   <= beat1_d;
      dp0_q     <= dp0_d;
      dp1_q     <= dp1_d;
      seeds_q   <= seeds_d;
      res_q     <= res_d;
      rst_cnt_q <= rst_cnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_linear_pe_stream_scheduler.sv
// Self-checking bench for linear_pe_stream_scheduler: a table of whole jobs
// plus hand-written reset, zero-config, error/flush and mid-job reset sequences.
module tb_linear_pe_stream_scheduler;

  localparam int W0 = 16;
  localparam int W1 = 16;
  localparam int WP = 32;
  localparam int LW = 16;
  localparam int CW = 16;

  logic          clk, rst, cfg_start;
  logic [LW-1:0] cfg_len;
  logic [CW-1:0] cfg_count;
  logic          busy, done, err;
  logic [W0-1:0] s_axis_op0_tdata, m_axis_l_tdata;
  logic          s_axis_op0_tvalid, s_axis_op0_tready;
  logic          m_axis_l_tvalid, m_axis_l_tready, m_axis_l_tlast;
  logic [W1-1:0] s_axis_op1_tdata, m_axis_t_tdata;
  logic          s_axis_op1_tvalid, s_axis_op1_tready;
  logic          m_axis_t_tvalid, m_axis_t_tready, m_axis_t_tlast;
  logic [WP-1:0] m_axis_u_tdata;
  logic          m_axis_u_tvalid, m_axis_u_tready, m_axis_u_tlast;
  logic [WP-1:0] s_axis_d_tdata, m_axis_res_tdata;
  logic          s_axis_d_tvalid, s_axis_d_tready, s_axis_d_tlast;
  logic          m_axis_res_tvalid, m_axis_res_tready, m_axis_res_tlast;
  logic          pe_err_unalligned_data, pe_rst;

  linear_pe_stream_scheduler #(
    .DATA_WIDTH_OP0(W0), .DATA_WIDTH_OP1(W1), .DATA_WIDTH_PSUM(WP),
    .LEN_WIDTH(LW), .CNT_WIDTH(CW), .PE_RST_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_len(cfg_len), .cfg_count(cfg_count),
    .busy(busy), .done(done), .err(err),
    .s_axis_op0_tdata(s_axis_op0_tdata), .s_axis_op0_tvalid(s_axis_op0_tvalid),
    .s_axis_op0_tready(s_axis_op0_tready),
    .m_axis_l_tdata(m_axis_l_tdata), .m_axis_l_tvalid(m_axis_l_tvalid),
    .m_axis_l_tready(m_axis_l_tready), .m_axis_l_tlast(m_axis_l_tlast),
    .s_axis_op1_tdata(s_axis_op1_tdata), .s_axis_op1_tvalid(s_axis_op1_tvalid),
    .s_axis_op1_tready(s_axis_op1_tready),
    .m_axis_t_tdata(m_axis_t_tdata), .m_axis_t_tvalid(m_axis_t_tvalid),
    .m_axis_t_tready(m_axis_t_tready), .m_axis_t_tlast(m_axis_t_tlast),
    .m_axis_u_tdata(m_axis_u_tdata), .m_axis_u_tvalid(m_axis_u_tvalid),
    .m_axis_u_tready(m_axis_u_tready), .m_axis_u_tlast(m_axis_u_tlast),
    .s_axis_d_tdata(s_axis_d_tdata), .s_axis_d_tvalid(s_axis_d_tvalid),
    .s_axis_d_tready(s_axis_d_tready), .s_axis_d_tlast(s_axis_d_tlast),
    .m_axis_res_tdata(m_axis_res_tdata), .m_axis_res_tvalid(m_axis_res_tvalid),
    .m_axis_res_tready(m_axis_res_tready), .m_axis_res_tlast(m_axis_res_tlast),
    .pe_err_unalligned_data(pe_err_unalligned_data), .pe_rst(pe_rst)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int len;
    int count;
    bit l_toggle;
    bit hold_res;
    bit poke;
    int exp_l;
    int exp_t;
    int exp_u;
    int exp_r;
  } job_t;

  job_t jobs[5];

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_all(input logic v);
    s_axis_op0_tvalid = v;
    s_axis_op1_tvalid = v;
    s_axis_d_tvalid   = v;
    m_axis_l_tready   = v;
    m_axis_t_tready   = v;
    m_axis_u_tready   = v;
    m_axis_res_tready = v;
    s_axis_d_tlast    = v;
  endtask

  task automatic check_off(input string tag);
    check({tag, "_l_vld"},   m_axis_l_tvalid,   0);
    check({tag, "_l_last"},  m_axis_l_tlast,    0);
    check({tag, "_op0_rdy"}, s_axis_op0_tready, 0);
    check({tag, "_t_vld"},   m_axis_t_tvalid,   0);
    check({tag, "_t_last"},  m_axis_t_tlast,    0);
    check({tag, "_op1_rdy"}, s_axis_op1_tready, 0);
    check({tag, "_u_vld"},   m_axis_u_tvalid,   0);
    check({tag, "_u_last"},  m_axis_u_tlast,    0);
    check({tag, "_d_rdy"},   s_axis_d_tready,   0);
    check({tag, "_res_vld"}, m_axis_res_tvalid, 0);
    check({tag, "_res_last"},m_axis_res_tlast,  0);
  endtask

  // ---------------- driver: one whole job against a PE model ----------------
  task automatic run_job(input job_t j);
    int n0, n1, nu, nr, tot;
    bit fin, done_exp, r_ok;
    n0 = 0; n1 = 0; nu = 0; nr = 0; fin = 0; done_exp = 0;
    tot = j.len * j.count;
    drive_all(1'b0);
    cfg_len   = LW'(j.len);
    cfg_count = CW'(j.count);
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      s_axis_op0_tvalid = 1'b1;
      s_axis_op0_tdata  = W0'(32'h1000 + n0);
      s_axis_op1_tvalid = 1'b1;
      s_axis_op1_tdata  = W1'(32'h2000 + n1);
      m_axis_l_tready   = j.l_toggle ? ((cyc % 2) == 0) : 1'b1;
      m_axis_t_tready   = 1'b1;
      m_axis_u_tready   = 1'b1;
      m_axis_res_tready = 1'b1;
      if (j.hold_res)
        r_ok = (nr < j.count) && (n0 >= tot) && (n1 >= tot) && (nu >= j.count);
      else
        r_ok = (nr < j.count) && (n0 >= (nr + 1) * j.len) && (n1 >= (nr + 1) * j.len) && (nu > nr);
      s_axis_d_tvalid = r_ok;
      s_axis_d_tdata  = 32'hA000_0000 + WP'(nr);
      s_axis_d_tlast  = 1'b1;
      cfg_start = j.poke && (cyc == 2);
      if (j.poke && cyc == 2) begin
        cfg_len   = LW'(7);
        cfg_count = CW'(9);
      end
      #3;
      if (cyc == 0) check("busy_run", busy, 1);
      check("done_level", done, done_exp);
      if (done_exp) begin
        check("busy_at_done", busy, 0);
        check("err_at_done", err, 0);
        fin = 1;
      end else begin
        check("l_vld", m_axis_l_tvalid, n0 < tot);
        check("op0_rdy", s_axis_op0_tready, m_axis_l_tvalid && m_axis_l_tready);
        if (m_axis_l_tvalid && m_axis_l_tready) begin
          check("l_data", m_axis_l_tdata, W0'(32'h1000 + n0));
          check("l_last", m_axis_l_tlast, (n0 % j.len) == j.len - 1);
          n0++;
        end
        check("t_vld", m_axis_t_tvalid, n1 < tot);
        if (m_axis_t_tvalid && m_axis_t_tready) begin
          check("t_data", m_axis_t_tdata, W1'(32'h2000 + n1));
          check("t_last", m_axis_t_tlast, (n1 % j.len) == j.len - 1);
          n1++;
        end
        check("u_vld", m_axis_u_tvalid, nu < j.count);
        if (m_axis_u_tvalid && m_axis_u_tready) begin
          check("u_data", m_axis_u_tdata, 0);
          check("u_last", m_axis_u_tlast, 1);
          nu++;
        end
        check("d_rdy", s_axis_d_tready, 1);
        check("res_vld", m_axis_res_tvalid, r_ok);
        if (r_ok && s_axis_d_tready) begin
          check("res_data", m_axis_res_tdata, 32'hA000_0000 + WP'(nr));
          check("res_last", m_axis_res_tlast, nr == j.count - 1);
          if (nr == j.count - 1) done_exp = 1;
          nr++;
        end
      end
      step();
    end
    drive_all(1'b0);
    cfg_start = 1'b0;
    #3;
    check("done_pulse_end", done, 0);
    if (!fin) check("job_timeout", 0, 1);
    check("n_l", n0, j.exp_l);
    check("n_t", n1, j.exp_t);
    check("n_u", nu, j.exp_u);
    check("n_res", nr, j.exp_r);
    step();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n0, flush_cycles;
    jobs[0] = '{len: 5, count: 3, l_toggle: 0, hold_res: 0, poke: 0, exp_l: 15, exp_t: 15, exp_u: 3, exp_r: 3};
    jobs[1] = '{len: 4, count: 2, l_toggle: 1, hold_res: 0, poke: 0, exp_l: 8,  exp_t: 8,  exp_u: 2, exp_r: 2};
    jobs[2] = '{len: 3, count: 4, l_toggle: 0, hold_res: 1, poke: 0, exp_l: 12, exp_t: 12, exp_u: 4, exp_r: 4};
    jobs[3] = '{len: 1, count: 1, l_toggle: 0, hold_res: 0, poke: 0, exp_l: 1,  exp_t: 1,  exp_u: 1, exp_r: 1};
    jobs[4] = '{len: 2, count: 3, l_toggle: 1, hold_res: 1, poke: 1, exp_l: 6,  exp_t: 6,  exp_u: 3, exp_r: 3};

    // Reset with every input pushing activity.
    rst = 1'b1;
    cfg_start = 1'b1;
    cfg_len = LW'(3);
    cfg_count = CW'(2);
    s_axis_op0_tdata = '0;
    s_axis_op1_tdata = '0;
    s_axis_d_tdata = '0;
    pe_err_unalligned_data = 1'b1;
    drive_all(1'b1);
    step();
    step();
    #3;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_pe_rst", pe_rst, 0);
    check_off("rst");
    step();
    rst = 1'b0;
    cfg_start = 1'b0;
    step();
    #3;
    check("idle_err_ignored", err, 0);
    check("idle_busy", busy, 0);
    check_off("idle");
    step();
    pe_err_unalligned_data = 1'b0;

    // Zero configurations: done next cycle, no activity.
    for (int z = 0; z < 2; z++) begin
      cfg_len   = (z == 0) ? LW'(5) : LW'(0);
      cfg_count = (z == 0) ? CW'(0) : CW'(3);
      cfg_start = 1'b1;
      step();
      cfg_start = 1'b0;
      #3;
      check("zero_done", done, 1);
      check("zero_busy", busy, 0);
      check_off("zero");
      step();
      #3;
      check("zero_done_clr", done, 0);
      step();
    end

    for (int k = 0; k < 5; k++) run_job(jobs[k]);

    // Misalignment error after beat 7 of a 5x4 job.
    drive_all(1'b0);
    cfg_len = LW'(5);
    cfg_count = CW'(4);
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    n0 = 0;
    for (int cyc = 0; cyc < 40 && n0 < 8; cyc++) begin
      drive_all(1'b1);
      s_axis_d_tvalid = 1'b0;
      s_axis_op0_tdata = W0'(n0);
      #3;
      if (m_axis_l_tvalid && m_axis_l_tready) n0++;
      step();
    end
    check("err_beats_reached", n0, 8);
    pe_err_unalligned_data = 1'b1;
    step();
    pe_err_unalligned_data = 1'b0;
    #3;
    check("flush_busy", busy, 1);
    check("flush_err", err, 1);
    check("flush_pe_rst", pe_rst, 1);
    check("flush_done", done, 0);
    check_off("flush");
    flush_cycles = 1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      step();
      #3;
      check("flush_no_done", done, 0);
      if (!pe_rst) break;
      check_off("flush_n");
      flush_cycles++;
    end
    check("pe_rst_cycles", flush_cycles, 4);
    check("post_flush_busy", busy, 0);
    check("err_sticky", err, 1);
    step();
    cfg_len = LW'(0);
    cfg_count = CW'(0);
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    #3;
    check("err_cleared", err, 0);
    check("err_clear_done", done, 1);
    step();

    // Reset in the middle of a job.
    cfg_len = LW'(3);
    cfg_count = CW'(2);
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      drive_all(1'b1);
      s_axis_d_tvalid = 1'b0;
      step();
    end
    #3;
    check("midrst_pre_busy", busy, 1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #3;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_err", err, 0);
    check("midrst_pe_rst", pe_rst, 0);
    check_off("midrst");
    for (int cyc = 0; cyc < 3; cyc++) begin
      step();
      #3;
      check("midrst_no_done", done, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
